// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encoding and
// default framing constants.
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic [7:0]  SOF_DEFAULT     = 8'hA5;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd480;

  // The inter-byte timer only runs while a frame is being assembled.
  function automatic logic timer_active(input state_t st);
    return (st == ST_LEN) || (st == ST_PAYLOAD) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file with one write port and a
// combinational read port that returns zero beyond the held frame length.
module uart_frame_buf
  import uart_frame_rx_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [7:0]    rd_addr,
  input  logic [7:0]    frame_len,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < frame_len) rd_data = mem[rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler behind the UART receiver: SOF, LEN, payload, CHK with
// mod-256 checksum, inter-byte timeout, and a held-frame handshake.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int          MAX_LEN       = 16,
  parameter logic [7:0]  SOF           = SOF_DEFAULT,
  parameter logic [15:0] TIMEOUT_TICKS = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       frame_valid,
  output logic [7:0] frame_len,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       overrun
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = TIMEOUT_TICKS - 16'd1;

  state_t      state, next_state;
  logic [15:0] timer;
  logic [7:0]  sum, len, idx;
  logic [7:0]  sum_chk;
  logic        tmo, chk_ok, len_bad, we;
  logic        err_chk_d, err_len_d, err_timeout_d, overrun_d;

  assign sum_chk = sum + rx_data;
  assign chk_ok  = (sum_chk == 8'h00);
  assign len_bad = (rx_data > MAX_LEN_B);
  // A byte in the same cycle as the final tick clears the timer instead.
  assign tmo     = timer_active(state) && !rx_done_tick && s_tick && (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (rx_done_tick && rx_data == SOF) next_state = ST_LEN;
      ST_LEN:     if (rx_done_tick) begin
                    if (len_bad)               next_state = ST_IDLE;
                    else if (rx_data == 8'h00) next_state = ST_CHK;
                    else                       next_state = ST_PAYLOAD;
                  end else if (tmo)            next_state = ST_IDLE;
      ST_PAYLOAD: if (rx_done_tick) begin
                    if (idx == len - 8'd1)     next_state = ST_CHK;
                  end else if (tmo)            next_state = ST_IDLE;
      ST_CHK:     if (rx_done_tick)            next_state = chk_ok ? ST_HOLD : ST_IDLE;
                  else if (tmo)                next_state = ST_IDLE;
      ST_HOLD:    if (frame_ack)               next_state = ST_IDLE;
      default:                                 next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    err_len_d     = (state == ST_LEN)  && rx_done_tick && len_bad;
    err_chk_d     = (state == ST_CHK)  && rx_done_tick && !chk_ok;
    err_timeout_d = tmo;
    overrun_d     = (state == ST_HOLD) && rx_done_tick;
    we            = (state == ST_PAYLOAD) && rx_done_tick;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      frame_len   <= 8'h00;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
      timer       <= 16'd0;
      sum         <= 8'h00;
    end else begin
      frame_valid <= (next_state == ST_HOLD);
      err_chk     <= err_chk_d;
      err_len     <= err_len_d;
      err_timeout <= err_timeout_d;
      overrun     <= overrun_d;
      if (state == ST_CHK && rx_done_tick && chk_ok) frame_len <= len;
      if (!timer_active(state) || rx_done_tick || tmo) timer <= 16'd0;
      else if (s_tick)                                 timer <= timer + 16'd1;
      if (state == ST_LEN && rx_done_tick)  sum <= rx_data;
      else if (we)                          sum <= sum_chk;
    end
  end

  // Length and write index are overwritten before every use.
  always_ff @(posedge clk) begin
    if (state == ST_LEN && rx_done_tick) begin
      len <= rx_data;
      idx <= 8'h00;
    end else if (we) begin
      idx <= idx + 8'd1;
    end
  end

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk       (clk),
    .we        (we),
    .waddr     (idx[AW-1:0]),
    .wdata     (rx_data),
    .rd_addr   (rd_addr),
    .frame_len (frame_len),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: framing, checksum, length, timeout,
// overrun and reset scenarios with hand-computed expectations.
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       frame_ack = 1'b0;
  logic       err_chk, err_len, err_timeout, overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_frame_rx dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_ack    (frame_ack),
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .overrun      (overrun)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd_addr = 8'h00;
    #1;
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
    checks++;
    if (frame_len !== 8'h00) begin failures++; $display("FAIL reset_len got=%h exp=00", frame_len); end
    checks++;
    if ({err_chk, err_len, err_timeout, overrun} !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0000", {err_chk, err_len, err_timeout, overrun});
    end
    checks++;
    if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL good_early_valid got=%b exp=0", frame_valid); end
    send_byte(8'h97);
    checks++;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", frame_valid); end
    checks++;
    if (frame_len !== 8'd3) begin failures++; $display("FAIL good_len got=%h exp=03", frame_len); end
    checks++;
    if (err_chk !== 1'b0) begin failures++; $display("FAIL good_err_chk got=%b exp=0", err_chk); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      #1;
      checks++;
      if (rd_data !== exp_rd[i]) begin
        failures++; $display("FAIL good_rd addr=%0d got=%h exp=%h", i, rd_data, exp_rd[i]);
      end
    end
    rd_addr = 8'h00;
    ack();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL good_ack_valid got=%b exp=0", frame_valid); end
  endtask

  task automatic test_bad_chk();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h98);
    checks++;
    if (err_chk !== 1'b1) begin failures++; $display("FAIL bad_chk_pulse got=%b exp=1", err_chk); end
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL bad_chk_valid got=%b exp=0", frame_valid); end
    @(negedge clk);
    checks++;
    if (err_chk !== 1'b0) begin failures++; $display("FAIL bad_chk_width got=%b exp=0", err_chk); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin
      failures++; $display("FAIL bad_chk_recover got=%b/%h exp=1/01", frame_valid, frame_len);
    end
    ack();
  endtask

  task automatic test_len_and_empty();
    send_byte(8'hA5); send_byte(8'h20);
    checks++;
    if (err_len !== 1'b1) begin failures++; $display("FAIL len_err_pulse got=%b exp=1", err_len); end
    @(negedge clk);
    checks++;
    if (err_len !== 1'b0) begin failures++; $display("FAIL len_err_width got=%b exp=0", err_len); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd0) begin
      failures++; $display("FAIL empty_frame got=%b/%h exp=1/00", frame_valid, frame_len);
    end
    rd_addr = 8'h00;
    #1;
    checks++;
    if (rd_data !== 8'h00) begin failures++; $display("FAIL empty_rd got=%h exp=00", rd_data); end
    ack();
  endtask

  task automatic test_garbage();
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++;
    if ({err_chk, err_len, err_timeout, overrun} !== 4'b0000 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL garbage_quiet got=%b valid=%b exp=0000 valid=0",
                           {err_chk, err_len, err_timeout, overrun}, frame_valid);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    checks++;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL garbage_frame got=%b exp=1", frame_valid); end
    ack();
  endtask

  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    for (int i = 0; i < 479; i++) tick();
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", err_timeout); end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=1", err_timeout); end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_width got=%b exp=0", err_timeout); end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    for (int i = 0; i < 479; i++) tick();
    send_byte(8'h22);
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_479 got=%b exp=0", err_timeout); end
    send_byte(8'hCB);
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd2) begin
      failures++; $display("FAIL tmo_479_frame got=%b/%h exp=1/02", frame_valid, frame_len);
    end
    ack();
  endtask

  task automatic test_overrun();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    send_byte(8'h55);
    checks++;
    if (overrun !== 1'b1 || frame_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_held got=%b/%b exp=1/1", overrun, frame_valid);
    end
    rd_addr = 8'h00;
    #1;
    checks++;
    if (rd_data !== 8'h7E) begin failures++; $display("FAIL overrun_frozen got=%h exp=7E", rd_data); end
    @(negedge clk);
    frame_ack = 1'b1;
    rx_done_tick = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_done_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL overrun_ack got=%b/%b exp=1/0", overrun, frame_valid);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    checks++;
    if (frame_valid !== 1'b1 || err_chk !== 1'b0) begin
      failures++; $display("FAIL overrun_after got=%b/%b exp=1/0", frame_valid, err_chk);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (frame_valid !== 1'b0 || frame_len !== 8'h00) begin
      failures++; $display("FAIL mid_reset got=%b/%h exp=0/00", frame_valid, frame_len);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    rd_addr = 8'h00;
    #1;
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd1 || rd_data !== 8'h7E) begin
      failures++; $display("FAIL mid_reset_frame got=%b/%h/%h exp=1/01/7E", frame_valid, frame_len, rd_data);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_and_empty();
    test_garbage();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
